// File: rtl/tl_cntr_n.sv
// tl_cntr_n: N-approach round-robin traffic light controller.
//
// Approaches are served in round-robin order, and approaches with no traffic are
// skipped. A green phase ends only when some other approach is waiting. It ends
// once MIN_GREEN has elapsed and the active approach is idle, or when MAX_GREEN
// is reached. Each green is followed by YELLOW_TIME cycles of yellow and
// ALL_RED_TIME cycles of all-red. The next approach is chosen in the last
// all-red cycle.
//
// Optional feature, enabled by defining the macro TL_PED_EN:
//   A pedestrian request latches a pending flag. At the end of the all-red
//   phase the controller then enters WALK for WALK_TIME cycles, with all lights
//   red. From WALK it goes directly to the next green.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-high reset
//   T        in   [NUM_DIR] traffic sensor per approach (1 = vehicle waiting)
//   L        out  [2*NUM_DIR] light of approach i on L[2i+1:2i]
//                 (00 green, 01 yellow, 10 red)
//   act_dir  out  index of the approach owning the current phase
//   phase    out  00 GREEN, 01 YELLOW, 10 ALL_RED, 11 WALK
//   ped_req  in   pedestrian request, level or pulse (TL_PED_EN only)
//   walk     out  pedestrian walk indication (TL_PED_EN only)
module tl_cntr_n #(
  parameter int unsigned NUM_DIR      = 2,
  parameter int unsigned MIN_GREEN    = 4,
  parameter int unsigned MAX_GREEN    = 8,
  parameter int unsigned YELLOW_TIME  = 2,
  parameter int unsigned ALL_RED_TIME = 1,
  parameter int unsigned WALK_TIME    = 5
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [NUM_DIR-1:0]                          T,
  output logic [2*NUM_DIR-1:0]                        L,
  output logic [((NUM_DIR > 2) ? $clog2(NUM_DIR) : 1)-1:0] act_dir,
  output logic [1:0]                                  phase
`ifdef TL_PED_EN
  ,
  input  logic                                        ped_req,
  output logic                                        walk
`endif
);

  localparam int unsigned DW = (NUM_DIR > 2) ? $clog2(NUM_DIR) : 1;

  // The timer is sized for the longest duration parameter.
  localparam int unsigned MaxA   = (MAX_GREEN > YELLOW_TIME) ? MAX_GREEN : YELLOW_TIME;
  localparam int unsigned MaxB   = (ALL_RED_TIME > WALK_TIME) ? ALL_RED_TIME : WALK_TIME;
  localparam int unsigned MaxDur = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned TW     = (MaxDur > 1) ? $clog2(MaxDur) : 1;

  typedef enum logic [1:0] {
    StGreen  = 2'b00,
    StYellow = 2'b01,
    StAllRed = 2'b10,
    StWalk   = 2'b11
  } phase_e;

  phase_e          phase_q, phase_d;
  logic [DW-1:0]   dir_q, dir_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [DW-1:0]   next_dir;
  logic            found;
  logic            other_req;
  logic            cur_req;
  logic            timer_max;

`ifdef TL_PED_EN
  logic ped_pend_q, ped_pend_d;
`endif

  // Requests seen from the active approach and from all the others.
  always_comb begin
    cur_req   = |(T & (NUM_DIR'(1) << dir_q));
    other_req = |(T & ~(NUM_DIR'(1) << dir_q));
`ifdef TL_PED_EN
    other_req = other_req | ped_pend_q;
`endif
  end

  // Round-robin search starting after the active approach. When nobody is
  // waiting, fall back to the neighbouring approach.
  always_comb begin
    next_dir = DW'((32'(dir_q) + 32'd1) % NUM_DIR);
    found    = 1'b0;
    for (int unsigned k = 1; k < NUM_DIR; k++) begin
      if (!found && T[DW'((32'(dir_q) + k) % NUM_DIR)]) begin
        next_dir = DW'((32'(dir_q) + k) % NUM_DIR);
        found    = 1'b1;
      end
    end
  end

  assign timer_max = (timer_q == TW'(MAX_GREEN - 1));

  always_comb begin
    phase_d = phase_q;
    dir_d   = dir_q;
    timer_d = timer_q + TW'(1);
    unique case (phase_q)
      StGreen: begin
        if (other_req && (timer_q >= TW'(MIN_GREEN - 1)) && (!cur_req || timer_max)) begin
          phase_d = StYellow;
          timer_d = '0;
        end else if (timer_max) begin
          timer_d = timer_q;  // saturate; green is held while nobody else waits
        end
      end
      StYellow: begin
        if (timer_q == TW'(YELLOW_TIME - 1)) begin
          phase_d = StAllRed;
          timer_d = '0;
        end
      end
      StAllRed: begin
        if (timer_q == TW'(ALL_RED_TIME - 1)) begin
          timer_d = '0;
`ifdef TL_PED_EN
          if (ped_pend_q) begin
            phase_d = StWalk;
          end else begin
            phase_d = StGreen;
            dir_d   = next_dir;
          end
`else
          phase_d = StGreen;
          dir_d   = next_dir;
`endif
        end
      end
      StWalk: begin
`ifdef TL_PED_EN
        if (timer_q == TW'(WALK_TIME - 1)) begin
          phase_d = StGreen;
          dir_d   = next_dir;
          timer_d = '0;
        end
`else
        // Unreachable without the pedestrian feature.
        phase_d = StGreen;
        timer_d = '0;
`endif
      end
      default: begin
        phase_d = StGreen;
        timer_d = '0;
      end
    endcase
  end

`ifdef TL_PED_EN
  // The flag is cleared on WALK entry, but a request in that same cycle wins.
  always_comb begin
    ped_pend_d = ped_pend_q;
    if (phase_q == StAllRed && phase_d == StWalk) begin
      ped_pend_d = 1'b0;
    end
    if (ped_req) begin
      ped_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ped_pend_q <= 1'b0;
    end else begin
      ped_pend_q <= ped_pend_d;
    end
  end

  assign walk = (phase_q == StWalk);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= StGreen;
      dir_q   <= '0;
      timer_q <= '0;
    end else begin
      phase_q <= phase_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
    end
  end

  // Light decode from registered state only, so L changes only after a clock
  // edge or on reset.
  always_comb begin
    L = '0;
    for (int unsigned i = 0; i < NUM_DIR; i++) begin
      if (DW'(i) == dir_q) begin
        unique case (phase_q)
          StGreen:  L[2*i +: 2] = 2'b00;
          StYellow: L[2*i +: 2] = 2'b01;
          default:  L[2*i +: 2] = 2'b10;
        endcase
      end else begin
        L[2*i +: 2] = 2'b10;
      end
    end
  end

  assign act_dir = dir_q;
  assign phase   = phase_q;

endmodule

// File: tb/tb_tl_cntr_n.sv
// Self-checking bench for tl_cntr_n. It uses a two-approach instance with
// default timing for the vector table, the asynchronous-reset sequence and the
// optional pedestrian sequence (TL_PED_EN). A four-approach instance exercises
// skipping of idle approaches and round-robin ordering.
module tb_tl_cntr_n;

  logic       clk;
  logic       reset;
  logic [1:0] t2;
  logic [3:0] l2;
  logic [0:0] dir2;
  logic [1:0] ph2;

  logic       rst4;
  logic [3:0] t4;
  logic [7:0] l4;
  logic [1:0] dir4;
  logic [1:0] ph4;

`ifdef TL_PED_EN
  logic ped_req, walk;
  logic ped_req4, walk4;
`endif

  int checks = 0;
  int errors = 0;

  tl_cntr_n u_dut2 (
    .clk     (clk),
    .reset   (reset),
    .T       (t2),
    .L       (l2),
    .act_dir (dir2),
    .phase   (ph2)
`ifdef TL_PED_EN
    ,
    .ped_req (ped_req),
    .walk    (walk)
`endif
  );

  tl_cntr_n #(.NUM_DIR(4)) u_dut4 (
    .clk     (clk),
    .reset   (rst4),
    .T       (t4),
    .L       (l4),
    .act_dir (dir4),
    .phase   (ph4)
`ifdef TL_PED_EN
    ,
    .ped_req (ped_req4),
    .walk    (walk4)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst;  // pulse reset before applying this vector
    logic [1:0] t;
    int         n;    // clock edges to run
    logic [3:0] l;
    logic [0:0] d;
    logic [1:0] ph;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 'b%0b, expected 'b%0b", name, got, exp);
    end
  endtask

  // All stimulus and sampling happens 1 time unit after a rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset2();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    clk   = 1'b0;
    reset = 1'b1;
    rst4  = 1'b1;
    t2    = '0;
    t4    = '0;
`ifdef TL_PED_EN
    ped_req  = 1'b0;
    ped_req4 = 1'b0;
`endif

    //          rst   T      n   L        dir   phase
    vecs[0]  = '{1'b1, 2'b01, 0,  4'b1000, 1'b0, 2'b00};  // reset state
    vecs[1]  = '{1'b0, 2'b01, 50, 4'b1000, 1'b0, 2'b00};  // no contention, held
    vecs[2]  = '{1'b1, 2'b10, 3,  4'b1000, 1'b0, 2'b00};  // still inside min green
    vecs[3]  = '{1'b0, 2'b10, 1,  4'b1001, 1'b0, 2'b01};  // yellow after 4 green
    vecs[4]  = '{1'b0, 2'b10, 1,  4'b1001, 1'b0, 2'b01};
    vecs[5]  = '{1'b0, 2'b10, 1,  4'b1010, 1'b0, 2'b10};  // all-red
    vecs[6]  = '{1'b0, 2'b10, 1,  4'b0010, 1'b1, 2'b00};  // dir1 green at edge 7
    vecs[7]  = '{1'b0, 2'b10, 20, 4'b0010, 1'b1, 2'b00};  // dir1 held
    vecs[8]  = '{1'b1, 2'b11, 7,  4'b1000, 1'b0, 2'b00};  // both waiting: max green
    vecs[9]  = '{1'b0, 2'b11, 1,  4'b1001, 1'b0, 2'b01};
    vecs[10] = '{1'b0, 2'b11, 3,  4'b0010, 1'b1, 2'b00};
    vecs[11] = '{1'b0, 2'b11, 7,  4'b0010, 1'b1, 2'b00};
    vecs[12] = '{1'b0, 2'b11, 1,  4'b0110, 1'b1, 2'b01};  // dir1 yellow
    vecs[13] = '{1'b0, 2'b11, 3,  4'b1000, 1'b0, 2'b00};  // back to dir0 at 22
    vecs[14] = '{1'b1, 2'b10, 4,  4'b1001, 1'b0, 2'b01};
    vecs[15] = '{1'b0, 2'b00, 3,  4'b0010, 1'b1, 2'b00};  // withdrawn: default next

    for (int i = 0; i < 16; i++) begin
      t2 = vecs[i].t;
      if (vecs[i].rst) pulse_reset2();
      step(vecs[i].n);
      chk($sformatf("v%0d L", i), 32'(l2), 32'(vecs[i].l));
      chk($sformatf("v%0d act_dir", i), 32'(dir2), 32'(vecs[i].d));
      chk($sformatf("v%0d phase", i), 32'(ph2), 32'(vecs[i].ph));
    end

    // Asynchronous reset in the middle of dir1 yellow.
    t2 = 2'b11;
    pulse_reset2();
    step(19);
    chk("pre-async phase", 32'(ph2), 32'd1);
    chk("pre-async act_dir", 32'(dir2), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async L", 32'(l2), 32'b1000);
    chk("async act_dir", 32'(dir2), 32'd0);
    chk("async phase", 32'(ph2), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    t2 = 2'b10;
    step(6);
    chk("post-reset all-red", 32'(l2), 32'b1010);
    step(1);
    chk("post-reset L", 32'(l2), 32'b0010);
    chk("post-reset act_dir", 32'(dir2), 32'd1);

    // Four approaches: skipping idle ones and round-robin order.
    t4 = 4'b1000;
    @(posedge clk);
    #1 rst4 = 1'b0;
    chk("4w reset L", 32'(l4), 32'b10101000);
    step(4);
    chk("4w yellow L", 32'(l4), 32'b10101001);
    step(3);
    chk("4w skip L", 32'(l4), 32'b00101010);
    chk("4w skip act_dir", 32'(dir4), 32'd3);
    t4 = 4'b0101;
    step(7);
    chk("4w wrap L", 32'(l4), 32'b10101000);
    chk("4w wrap act_dir", 32'(dir4), 32'd0);
    step(7);
    chk("4w max green", 32'(ph4), 32'd0);
    step(1);
    chk("4w max yellow", 32'(l4), 32'b10101001);
    step(3);
    chk("4w rr L", 32'(l4), 32'b10001010);
    chk("4w rr act_dir", 32'(dir4), 32'd2);

`ifdef TL_PED_EN
    // One-cycle pedestrian request while dir0 is green and nobody else waits.
    t2 = 2'b00;
    pulse_reset2();
    chk("ped reset walk", 32'(walk), 32'd0);
    ped_req = 1'b1;
    step(1);
    ped_req = 1'b0;
    step(3);
    chk("ped yellow", 32'(ph2), 32'd1);
    step(3);
    chk("ped walk phase", 32'(ph2), 32'd3);
    chk("ped walk", 32'(walk), 32'd1);
    chk("ped walk L", 32'(l2), 32'b1010);
    step(4);
    chk("ped walk end", 32'(walk), 32'd1);
    step(1);
    chk("ped green L", 32'(l2), 32'b0010);
    chk("ped green act_dir", 32'(dir2), 32'd1);
    chk("ped green walk", 32'(walk), 32'd0);
    step(10);
    chk("ped served", 32'(ph2), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
